seg7_scan_n: RTL and testbench

Time-multiplexed seven-segment display driver for an N-digit common-anode-select display. It scans a configurable number of hex digits, with per-digit decimal points, leading-zero blanking and 16-level brightness PWM. A frame-synchronous shadow register prevents tearing. It sits between the CPU's display/debug register and the board's segment and digit-select pins, and is the multi-digit successor of the two-digit scanner.

---
 rtl/seg7_scan_n_if.sv | 24 ++
 rtl/seg7_scan_n.sv | 132 +++++++++++++
 tb/tb_seg7_scan_n.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_n_if.sv
// Display-side bundle of the seven-segment scanner: value/format requests in,
// multiplexed segment and digit-select pins out.
interface seg7_scan_n_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] I_show_num;
  logic [DIGITS-1:0]   I_dp;
  logic                I_blank_lz;
  logic [3:0]          I_bright;
  logic [6:0]          O_seg;
  logic                O_dp;
  logic [DIGITS-1:0]   O_an;
  logic                O_frame_done;

  modport master (
    output I_show_num, I_dp, I_blank_lz, I_bright,
    input  O_seg, O_dp, O_an, O_frame_done
  );

  modport slave (
    input  I_show_num, I_dp, I_blank_lz, I_bright,
    output O_seg, O_dp, O_an, O_frame_done
  );
endinterface

// File: rtl/seg7_scan_n.sv
// N-digit time-multiplexed seven-segment driver with per-frame shadow snapshot,
// leading-zero blanking, decimal points and 16-level brightness PWM.
module seg7_scan_n #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 10000
) (
  input  logic          I_clk,
  input  logic          I_rst,
  seg7_scan_n_if.slave  bus
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW+4:0] SD_W = (CW+5)'(SCAN_DIV);

  logic [CW-1:0]       cnt_reg;
  logic [IW-1:0]       idx_reg;
  logic                first_reg;
  logic [4*DIGITS-1:0] snap_num_reg;
  logic [DIGITS-1:0]   snap_dp_reg;
  logic                snap_lz_reg;
  logic [3:0]          snap_br_reg;
  logic [6:0]          seg_reg;
  logic                dp_reg;
  logic [DIGITS-1:0]   an_reg;
  logic                frame_done_reg;

  logic [6:0]          seg_next;
  logic                dp_next;
  logic [DIGITS-1:0]   an_next;
  logic                slot_end;
  logic                frame_end;
  logic [DIGITS-1:0]   blank_vec;
  logic [3:0]          nibble;
  logic [CW+4:0]       bright_prod;
  logic                bright_on;
  logic                lit;

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: glyph = 7'b1111110;
      4'h1: glyph = 7'b0110000;
      4'h2: glyph = 7'b1101101;
      4'h3: glyph = 7'b1111001;
      4'h4: glyph = 7'b0110011;
      4'h5: glyph = 7'b1011011;
      4'h6: glyph = 7'b1011111;
      4'h7: glyph = 7'b1110000;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1111011;
      4'hA: glyph = 7'b1110111;
      4'hB: glyph = 7'b0011111;
      4'hC: glyph = 7'b1001110;
      4'hD: glyph = 7'b0111101;
      4'hE: glyph = 7'b1001111;
      default: glyph = 7'b1000111;
    endcase
  endfunction

  // Digit k blanks when it and every more-significant nibble are zero.
  assign blank_vec[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lz
      assign blank_vec[gi] = snap_lz_reg && (snap_num_reg[4*DIGITS-1:4*gi] == '0);
    end
  endgenerate

  assign slot_end    = (cnt_reg == CW'(SCAN_DIV - 1));
  assign frame_end   = slot_end && (idx_reg == IW'(DIGITS - 1));
  assign nibble      = snap_num_reg[4*idx_reg +: 4];
  assign bright_prod = (CW+5)'({1'b0, snap_br_reg} + 5'd1) * SD_W;
  // cnt < floor(prod/16) is equivalent to 16*(cnt+1) <= prod, avoiding the divide.
  assign bright_on   = ({({1'b0, cnt_reg} + (CW+1)'(1)), 4'b0000} <= bright_prod);
  assign lit         = bright_on && !blank_vec[idx_reg];

  always_comb begin
    seg_next = 7'b0;
    dp_next  = 1'b0;
    an_next  = '0;
    if (lit) begin
      seg_next = glyph(nibble);
      dp_next  = snap_dp_reg[idx_reg];
      an_next  = DIGITS'(1) << idx_reg;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      cnt_reg        <= '0;
      idx_reg        <= '0;
      first_reg      <= 1'b1;
      snap_num_reg   <= '0;
      snap_dp_reg    <= '0;
      snap_lz_reg    <= 1'b0;
      snap_br_reg    <= 4'd0;
      seg_reg        <= 7'b0;
      dp_reg         <= 1'b0;
      an_reg         <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (first_reg || frame_end) begin
        snap_num_reg   <= bus.I_show_num;
        snap_dp_reg    <= bus.I_dp;
        snap_lz_reg    <= bus.I_blank_lz;
        snap_br_reg    <= bus.I_bright;
        frame_done_reg <= 1'b1;
      end
      // The post-reset load cycle holds the scan at digit 0 with outputs dark.
      if (first_reg) begin
        first_reg <= 1'b0;
        seg_reg   <= 7'b0;
        dp_reg    <= 1'b0;
        an_reg    <= '0;
      end else begin
        seg_reg <= seg_next;
        dp_reg  <= dp_next;
        an_reg  <= an_next;
        if (slot_end) begin
          cnt_reg <= '0;
          idx_reg <= frame_end ? '0 : idx_reg + IW'(1);
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end
    end
  end

  assign bus.O_seg        = seg_reg;
  assign bus.O_dp         = dp_reg;
  assign bus.O_an         = an_reg;
  assign bus.O_frame_done = frame_done_reg;
endmodule

// File: tb/tb_seg7_scan_n.sv
// Scoreboard bench for seg7_scan_n with 4 digits and a 16-cycle slot.
module tb_seg7_scan_n;
  localparam int ND = 4;
  localparam int SD = 16;

  typedef logic [12:0] exp_t; // {frame_done, an[3:0], seg[6:0], dp}

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  exp_t exp_v;
  exp_t obs_v;

  seg7_scan_n_if #(.DIGITS(ND)) bus ();

  seg7_scan_n #(.DIGITS(ND), .SCAN_DIV(SD)) dut (
    .I_clk (clk),
    .I_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_glyph(input logic [3:0] h);
    logic [6:0] tab [16];
    tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
            7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
            7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
            7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    return tab[h];
  endfunction

  function automatic exp_t exp_slot(input logic [15:0] num, input logic [3:0] dpv,
                                    input logic lz, input logic [3:0] br,
                                    input int k, input int c, input logic fd);
    logic       blank;
    int         thr;
    logic       en;
    logic [3:0] nib;
    logic [3:0] an;
    blank = lz && (k != 0) && ((num >> (4*k)) == 16'h0);
    thr   = ((int'(br) + 1) * SD) >> 4;
    en    = (c < thr) && !blank;
    nib   = num[4*k +: 4];
    an    = 4'b0001 << k;
    return {fd, en ? an : 4'b0, en ? ref_glyph(nib) : 7'b0, en ? dpv[k] : 1'b0};
  endfunction

  // Queues the expected outputs of one whole frame, optionally preceded by the
  // dark post-reset load cycle.
  task automatic push_frame(input logic [15:0] num, input logic [3:0] dpv,
                            input logic lz, input logic [3:0] br, input bit post);
    if (post) sb_q.push_back(13'b1_0000_0000000_0);
    for (int s = 0; s < ND*SD; s++)
      sb_q.push_back(exp_slot(num, dpv, lz, br, s / SD, s % SD, s == ND*SD-1));
  endtask

  task automatic drive(input logic [15:0] num, input logic [3:0] dpv,
                       input logic lz, input logic [3:0] br);
    bus.I_show_num = num;
    bus.I_dp       = dpv;
    bus.I_blank_lz = lz;
    bus.I_bright   = br;
  endtask

  task automatic restart(input logic [15:0] num, input logic [3:0] dpv,
                         input logic lz, input logic [3:0] br);
    drive(num, dpv, lz, br);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push_frame(num, dpv, lz, br, 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(16'($urandom), 4'($urandom), 1'($urandom), 4'($urandom));
      @(negedge clk);
      obs_v = {bus.O_frame_done, bus.O_an, bus.O_seg, bus.O_dp};
      n_checks++;
      if (obs_v !== 13'b0) begin
        n_fail++;
        $display("FAIL reset: cycle %0d outputs=%h required=0", i, obs_v);
      end
    end
    $display("test_reset: done, failures so far %0d", n_fail);
  endtask

  task automatic test_basic;
    int s;
    restart(16'h12AF, 4'b0000, 1'b0, 4'd15);
    s = 0;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      exp_v = sb_q.pop_front();
      obs_v = {bus.O_frame_done, bus.O_an, bus.O_seg, bus.O_dp};
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL basic: step %0d got %h required %h", s, obs_v, exp_v);
      end
      s++;
    end
    $display("test_basic: 12AF frame, failures so far %0d", n_fail);
  endtask

  task automatic test_lz;
    logic [15:0] nums [2];
    int s;
    nums = '{16'h0050, 16'h0000};
    for (int t = 0; t < 2; t++) begin
      restart(nums[t], 4'b1111, 1'b1, 4'd15);
      s = 0;
      while (sb_q.size() > 0) begin
        @(negedge clk);
        exp_v = sb_q.pop_front();
        obs_v = {bus.O_frame_done, bus.O_an, bus.O_seg, bus.O_dp};
        n_checks++;
        if (obs_v !== exp_v) begin
          n_fail++;
          $display("FAIL lz_%h: step %0d got %h required %h", nums[t], s, obs_v, exp_v);
        end
        s++;
      end
      $display("test_lz: value %h, failures so far %0d", nums[t], n_fail);
    end
  endtask

  task automatic test_bright;
    logic [3:0] brs [3];
    int s;
    brs = '{4'd3, 4'd0, 4'd8};
    for (int t = 0; t < 3; t++) begin
      restart(16'h8C3E, 4'b1010, 1'b0, brs[t]);
      s = 0;
      while (sb_q.size() > 0) begin
        @(negedge clk);
        exp_v = sb_q.pop_front();
        obs_v = {bus.O_frame_done, bus.O_an, bus.O_seg, bus.O_dp};
        n_checks++;
        if (obs_v !== exp_v) begin
          n_fail++;
          $display("FAIL bright_%0d: step %0d got %h required %h", brs[t], s, obs_v, exp_v);
        end
        s++;
      end
      $display("test_bright: level %0d, failures so far %0d", brs[t], n_fail);
    end
  endtask

  task automatic test_dp;
    logic [15:0] nums [2];
    logic        lzs  [2];
    int s;
    nums = '{16'h1234, 16'h0034};
    lzs  = '{1'b0, 1'b1};
    for (int t = 0; t < 2; t++) begin
      restart(nums[t], 4'b0100, lzs[t], 4'd15);
      s = 0;
      while (sb_q.size() > 0) begin
        @(negedge clk);
        exp_v = sb_q.pop_front();
        obs_v = {bus.O_frame_done, bus.O_an, bus.O_seg, bus.O_dp};
        n_checks++;
        if (obs_v !== exp_v) begin
          n_fail++;
          $display("FAIL dp_%h: step %0d got %h required %h", nums[t], s, obs_v, exp_v);
        end
        s++;
      end
      $display("test_dp: value %h lz %0d, failures so far %0d", nums[t], lzs[t], n_fail);
    end
  endtask

  task automatic test_back_to_back;
    int s;
    restart(16'h1111, 4'b0001, 1'b0, 4'd15);
    s = 0;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      if (s == 30) begin
        drive(16'h9876, 4'b1010, 1'b0, 4'd15);
        push_frame(16'h9876, 4'b1010, 1'b0, 4'd15, 1'b0);
      end
      exp_v = sb_q.pop_front();
      obs_v = {bus.O_frame_done, bus.O_an, bus.O_seg, bus.O_dp};
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL midframe: step %0d got %h required %h", s, obs_v, exp_v);
      end
      s++;
    end
    $display("test_back_to_back: two frames, failures so far %0d", n_fail);
  endtask

  task automatic test_reset_mid;
    int s;
    restart(16'h12AF, 4'b1111, 1'b0, 4'd15);
    for (int i = 0; i < 1 + 2*SD + 5; i++) begin
      @(negedge clk);
      exp_v = sb_q.pop_front();
      obs_v = {bus.O_frame_done, bus.O_an, bus.O_seg, bus.O_dp};
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL premid: step %0d got %h required %h", i, obs_v, exp_v);
      end
    end
    sb_q.delete();
    rst = 1'b1;
    @(negedge clk);
    obs_v = {bus.O_frame_done, bus.O_an, bus.O_seg, bus.O_dp};
    n_checks++;
    if (obs_v !== 13'b0) begin
      n_fail++;
      $display("FAIL midreset: outputs=%h required=0", obs_v);
    end
    rst = 1'b0;
    push_frame(16'h12AF, 4'b1111, 1'b0, 4'd15, 1'b1);
    s = 0;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      exp_v = sb_q.pop_front();
      obs_v = {bus.O_frame_done, bus.O_an, bus.O_seg, bus.O_dp};
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL postmid: step %0d got %h required %h", s, obs_v, exp_v);
      end
      s++;
    end
    $display("test_reset_mid: restart after digit 2, failures so far %0d", n_fail);
  endtask

  initial begin
    drive(16'h0, 4'h0, 1'b0, 4'd0);
    @(negedge clk);
    test_reset();
    test_basic();
    test_lz();
    test_bright();
    test_dp();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
